// File: rtl/fw_cmd_pkg.sv
// Shared definitions for the firmware command dispatcher: FSM state encoding
// and bit positions of the command and status words.
package fw_cmd_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_FINISH    = 2'd3
   } fw_cmd_state_t;

   localparam int FW_CMD_PAYLOAD_W = 22;

   // command word (sw_write32_0)
   localparam int CMD_SEL_LSB   = 0;
   localparam int CMD_OP_LSB    = 4;
   localparam int CMD_TOG_BIT   = 8;
   localparam int CMD_ABORT_BIT = 9;
   localparam int CMD_PAY_LSB   = 10;

   // status word (sw_read32_0)
   localparam int STS_SEL_LSB    = 0;
   localparam int STS_OP_LSB     = 4;
   localparam int STS_ACK_BIT    = 8;
   localparam int STS_BUSY_BIT   = 9;
   localparam int STS_DONE_BIT   = 10;
   localparam int STS_BADSEL_BIT = 11;
   localparam int STS_TMO_BIT    = 12;
   localparam int STS_COLL_BIT   = 13;
   localparam int STS_STATE_LSB  = 14;
   localparam int STS_CNT_LSB    = 16;

endpackage

// File: rtl/fw_cmd_timeout.sv
// WAIT_DONE watchdog: down-counter loaded on clear, counts while enabled and
// flags expiry on the TIMEOUT_CYCLES-th enabled cycle after a clear.
// Only instantiated when FW_CMD_TIMEOUT_EN is defined.
module fw_cmd_timeout #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic i_clk_sys,
   input  logic i_rst_b,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [31:0] LOAD = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] r_cnt;

   // reload on clear, count down while the dispatcher waits
   always_ff @(posedge i_clk_sys or negedge i_rst_b) begin
      if (!i_rst_b) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= LOAD;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 32'd1;
      end
   end

   assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/fw_cmd_dispatch.sv
// Command dispatcher between the AXI4-Lite register block and the per-IP
// test engines. A command is new when its toggle bit differs from ack_toggle.
// Optional WAIT_DONE timeout built when FW_CMD_TIMEOUT_EN is defined.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | waiting for a new toggle; bad selectors are acked here
//   START     | one-cycle ip_start strobe to the selected engine
//   WAIT_DONE | waiting for done pulse, busy fall, abort or timeout
//   FINISH    | ack toggle, set done, bump cmd_count
module fw_cmd_dispatch
   import fw_cmd_pkg::*;
#(
   parameter int          N_IP           = 8,
   parameter int          TIMEOUT_CYCLES = 1_000_000,
   parameter logic [15:0] CMD_COUNT_RST  = 16'h0000
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESETN,
   input  logic [31:0]                 sw_write32_0,
   output logic [31:0]                 sw_read32_0,
   output logic [N_IP-1:0]             ip_start,
   output logic [N_IP-1:0]             ip_abort,
   output logic [3:0]                  ip_op_code,
   output logic [FW_CMD_PAYLOAD_W-1:0] ip_payload,
   input  logic [N_IP-1:0]             ip_busy,
   input  logic [N_IP-1:0]             ip_done
);

   logic [31:0]                 r_cmd_q;
   logic                        r_abort_q;
   fw_cmd_state_t               r_state;
   logic                        r_ack;
   logic                        r_tog;
   logic [3:0]                  r_sel;
   logic [3:0]                  r_op;
   logic [FW_CMD_PAYLOAD_W-1:0] r_pay;
   logic                        r_done;
   logic                        r_err_sel;
   logic                        r_err_tmo;
   logic                        r_err_col;
   logic [15:0]                 r_cnt;
   logic                        r_busy_q;
   logic [N_IP-1:0]             r_start;
   logic [N_IP-1:0]             r_abort;

   logic [3:0]      w_cmd_sel;
   logic            w_new_cmd;
   logic            w_abort_edge;
   logic            w_bad_sel;
   logic [N_IP-1:0] w_sel_oh;
   logic            w_done_sel;
   logic            w_busy_sel;
   logic            w_busy_fall;
   logic            w_expire;
   logic [31:0]     w_status;

   assign w_cmd_sel    = r_cmd_q[CMD_SEL_LSB +: 4];
   assign w_new_cmd    = r_cmd_q[CMD_TOG_BIT] != r_ack;
   assign w_abort_edge = r_cmd_q[CMD_ABORT_BIT] & ~r_abort_q;
   assign w_bad_sel    = {1'b0, w_cmd_sel} >= 5'(N_IP);
   assign w_sel_oh     = N_IP'(1) << r_sel;
   assign w_done_sel   = |(ip_done & w_sel_oh);
   assign w_busy_sel   = |(ip_busy & w_sel_oh);
   assign w_busy_fall  = r_busy_q & ~w_busy_sel;

`ifdef FW_CMD_TIMEOUT_EN
   fw_cmd_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk_sys (S_AXI_ACLK),
      .i_rst_b   (S_AXI_ARESETN),
      .i_clr     (r_state == S_START),
      .i_en      (r_state == S_WAIT_DONE),
      .o_expire  (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   // register the software command word and keep the abort bit history
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_cmd_q   <= '0;
         r_abort_q <= 1'b0;
      end else begin
         r_cmd_q   <= sw_write32_0;
         r_abort_q <= r_cmd_q[CMD_ABORT_BIT];
      end
   end

   // dispatcher FSM with latched command fields, error flags and counter
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state   <= S_IDLE;
         r_ack     <= 1'b0;
         r_tog     <= 1'b0;
         r_sel     <= '0;
         r_op      <= '0;
         r_pay     <= '0;
         r_done    <= 1'b0;
         r_err_sel <= 1'b0;
         r_err_tmo <= 1'b0;
         r_err_col <= 1'b0;
         r_cnt     <= CMD_COUNT_RST;
         r_busy_q  <= 1'b0;
         r_start   <= '0;
         r_abort   <= '0;
      end else begin
         r_start <= '0;
         r_abort <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_new_cmd) begin
                  r_sel     <= w_cmd_sel;
                  r_op      <= r_cmd_q[CMD_OP_LSB +: 4];
                  r_pay     <= r_cmd_q[CMD_PAY_LSB +: FW_CMD_PAYLOAD_W];
                  r_tog     <= r_cmd_q[CMD_TOG_BIT];
                  r_done    <= 1'b0;
                  r_err_sel <= 1'b0;
                  r_err_tmo <= 1'b0;
                  r_err_col <= 1'b0;
                  if (w_bad_sel) begin
                     // rejected immediately: ack it so software can move on
                     r_err_sel <= 1'b1;
                     r_ack     <= r_cmd_q[CMD_TOG_BIT];
                  end else begin
                     r_state <= S_START;
                     r_start <= N_IP'(1) << w_cmd_sel;
                  end
               end
            end
            S_START: begin
               r_busy_q <= 1'b0;
               if (w_abort_edge) begin
                  r_abort   <= w_sel_oh;
                  r_err_tmo <= 1'b0;
                  r_state   <= S_FINISH;
               end else begin
                  r_state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               r_busy_q <= w_busy_sel;
               // completion outranks a simultaneous abort or timeout
               if (w_done_sel || w_busy_fall) begin
                  r_state <= S_FINISH;
               end else if (w_abort_edge) begin
                  r_abort   <= w_sel_oh;
                  r_err_tmo <= 1'b0;
                  r_state   <= S_FINISH;
               end else if (w_expire) begin
                  r_abort   <= w_sel_oh;
                  r_err_tmo <= 1'b1;
                  r_state   <= S_FINISH;
               end
            end
            S_FINISH: begin
               r_ack   <= r_tog;
               r_done  <= 1'b1;
               r_cnt   <= r_cnt + 16'd1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         // a toggle arriving while busy is flagged, then taken back in IDLE
         if ((r_state != S_IDLE) && (r_cmd_q[CMD_TOG_BIT] != r_tog)) begin
            r_err_col <= 1'b1;
         end
      end
   end

   // compose the status word from the registered state
   always_comb begin
      w_status = '0;
      w_status[STS_SEL_LSB +: 4]   = r_sel;
      w_status[STS_OP_LSB +: 4]    = r_op;
      w_status[STS_ACK_BIT]        = r_ack;
      w_status[STS_BUSY_BIT]       = r_state != S_IDLE;
      w_status[STS_DONE_BIT]       = r_done;
      w_status[STS_BADSEL_BIT]     = r_err_sel;
      w_status[STS_TMO_BIT]        = r_err_tmo;
      w_status[STS_COLL_BIT]       = r_err_col;
      w_status[STS_STATE_LSB +: 2] = r_state;
      w_status[STS_CNT_LSB +: 16]  = r_cnt;
   end

   assign sw_read32_0 = w_status;
   assign ip_start    = r_start;
   assign ip_abort    = r_abort;
   assign ip_op_code  = r_op;
   assign ip_payload  = r_pay;

endmodule
